// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- pipelined floating-point multiplier (default bfloat16 layout).
//
// Three registered stages with per-stage valid/ready handshaking:
//   S1  unpack operands, classify (zero/normal/inf/NaN), biased exponent sum
//   S2  significand product
//   S3  normalise, round, detect overflow/underflow, pack (the S3 register
//       drives out/error/out_valid directly)
// Subnormal inputs are flushed to signed zero; results never go subnormal.
//
// Build option:
//   FP_MUL_RNE_EN  defined   -> round to nearest, ties to even
//                  undefined -> truncate (round toward zero)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in1, in2    operands {sign, exp, frac}
//   in_valid    operands valid
//   in_ready    block accepts operands this cycle
//   out         product
//   error       00 none, 01 overflow, 10 underflow, 11 NaN
//   out_valid   result valid
//   out_ready   consumer accepts result
//   sticky_clr  clears err_sticky
//   err_sticky  {NaN, overflow, underflow} delivered since last clear

module fp_mul_pipe #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 7,
    parameter int DATA_WIDTH  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int ERROR_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in1,
    input  logic [DATA_WIDTH-1:0]  in2,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out,
    output logic [ERROR_WIDTH-1:0] error,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   sticky_clr,
    output logic [2:0]             err_sticky
);

    localparam int EW = EXP_WIDTH + 2;      // signed exponent working width
    localparam int SW = FRAC_WIDTH + 1;     // significand incl. hidden one
    localparam int PW = 2 * SW;             // significand product width

    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    localparam logic [ERROR_WIDTH-1:0] ERR_NONE = ERROR_WIDTH'(0);
    localparam logic [ERROR_WIDTH-1:0] ERR_OVF  = ERROR_WIDTH'(1);
    localparam logic [ERROR_WIDTH-1:0] ERR_UNF  = ERROR_WIDTH'(2);
    localparam logic [ERROR_WIDTH-1:0] ERR_NAN  = ERROR_WIDTH'(3);

    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // ------------------------------------------------------------------
    // Handshake: a stage advances when the one after it is empty or is
    // itself advancing in the same cycle.
    // ------------------------------------------------------------------
    logic s1_valid, s2_valid;
    logic s3_free, s2_adv, s1_adv, accept, deliver;

    assign s3_free  = ~out_valid | out_ready;
    assign s2_adv   = s2_valid & s3_free;
    assign s1_adv   = s1_valid & (~s2_valid | s2_adv);
    assign in_ready = ~s1_valid | s1_adv;
    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept)       s1_valid <= 1'b1;
            else if (s1_adv)  s1_valid <= 1'b0;

            if (s1_adv)       s2_valid <= 1'b1;
            else if (s2_adv)  s2_valid <= 1'b0;

            if (s2_adv)       out_valid <= 1'b1;
            else if (deliver) out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S1: unpack / classify / exponent sum
    // ------------------------------------------------------------------
    logic [EXP_WIDTH-1:0]  exp_a, exp_b;
    logic [FRAC_WIDTH-1:0] frac_a, frac_b;
    logic                  zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    cls_t                  cls_c;
    logic signed [EW-1:0]  esum_c;

    assign exp_a  = in1[DATA_WIDTH-2 -: EXP_WIDTH];
    assign exp_b  = in2[DATA_WIDTH-2 -: EXP_WIDTH];
    assign frac_a = in1[FRAC_WIDTH-1:0];
    assign frac_b = in2[FRAC_WIDTH-1:0];

    // exp == 0 covers both zero and subnormal: both are flushed to zero
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (exp_a == '1) && (frac_a == '0);
    assign inf_b  = (exp_b == '1) && (frac_b == '0);
    assign nan_a  = (exp_a == '1) && (frac_a != '0);
    assign nan_b  = (exp_b == '1) && (frac_b != '0);

    always_comb begin
        cls_c = CLS_NORM;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            cls_c = CLS_NAN;
        else if (inf_a || inf_b)
            cls_c = CLS_INF;
        else if (zero_a || zero_b)
            cls_c = CLS_ZERO;
    end

    assign esum_c = EW'(exp_a) + EW'(exp_b) - BIAS;

    cls_t                 s1_cls;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;
    logic [SW-1:0]        s1_sig_a, s1_sig_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cls   <= CLS_ZERO;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_sig_a <= '0;
            s1_sig_b <= '0;
        end else if (accept) begin
            s1_cls   <= cls_c;
            s1_sign  <= in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];
            s1_exp   <= esum_c;
            s1_sig_a <= {1'b1, frac_a};
            s1_sig_b <= {1'b1, frac_b};
        end
    end

    // ------------------------------------------------------------------
    // S2: significand product
    // ------------------------------------------------------------------
    cls_t                 s2_cls;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_cls  <= CLS_ZERO;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_prod <= '0;
        end else if (s1_adv) begin
            s2_cls  <= s1_cls;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= PW'(s1_sig_a) * PW'(s1_sig_b);
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise / round / pack
    // Both significands carry a hidden one, so the product's leading one is
    // at bit PW-1 or PW-2; a one-place shift puts it at PW-1 either way.
    // ------------------------------------------------------------------
    logic                  msb;
    logic [PW-1:0]         norm;
    logic [FRAC_WIDTH-1:0] mant;
    logic                  guard, rnd, stk, round_up;
    logic [FRAC_WIDTH:0]   mant_r;
    logic signed [EW-1:0]  e_norm, e_fin;
    logic                  unused_bits;

    assign msb    = s2_prod[PW-1];
    assign norm   = msb ? s2_prod : {s2_prod[PW-2:0], 1'b0};
    assign mant   = norm[PW-2 -: FRAC_WIDTH];
    assign guard  = norm[PW-2-FRAC_WIDTH];
    assign rnd    = norm[PW-3-FRAC_WIDTH];
    assign stk    = |norm[PW-4-FRAC_WIDTH:0];
    assign e_norm = s2_exp + {{(EW-1){1'b0}}, msb};

`ifdef FP_MUL_RNE_EN
    assign round_up    = guard & (rnd | stk | mant[0]);
    assign unused_bits = norm[PW-1];
`else
    assign round_up    = 1'b0;
    assign unused_bits = ^{norm[PW-1], guard, rnd, stk};
`endif

    // Rounding carry out of the fraction leaves it all-zero, which is the
    // correct renormalised fraction; only the exponent needs bumping.
    assign mant_r = {1'b0, mant} + {{FRAC_WIDTH{1'b0}}, round_up};
    assign e_fin  = e_norm + {{(EW-1){1'b0}}, mant_r[FRAC_WIDTH]};

    logic [DATA_WIDTH-1:0]  res_c;
    logic [ERROR_WIDTH-1:0] err_c;

    always_comb begin
        res_c = '0;
        err_c = ERR_NONE;
        case (s2_cls)
            CLS_NAN: begin
                res_c = QNAN;
                err_c = ERR_NAN;
            end
            CLS_INF: begin
                res_c = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            end
            CLS_ZERO: begin
                res_c = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
            end
            default: begin
                if (e_fin >= EXP_MAX) begin
                    res_c = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                    err_c = ERR_OVF;
                end else if (e_fin <= EXP_ZERO) begin
                    res_c = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
                    err_c = ERR_UNF;
                end else begin
                    res_c = {s2_sign, e_fin[EXP_WIDTH-1:0], mant_r[FRAC_WIDTH-1:0]};
                end
            end
        endcase
    end

    // Output register loads only when it is free, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            error <= ERR_NONE;
        end else if (s2_adv) begin
            out   <= res_c;
            error <= err_c;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a flag set in the same cycle as a clear survives.
    // ------------------------------------------------------------------
    logic [2:0] sticky_set;

    assign sticky_set = {deliver && (error == ERR_NAN),
                         deliver && (error == ERR_OVF),
                         deliver && (error == ERR_UNF)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= '0;
        else
            err_sticky <= (sticky_clr ? 3'b000 : err_sticky) | sticky_set;
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 7, stored fraction width.
REQ-003 SHALL have parameter DATA_WIDTH, default 1+EXP_WIDTH+FRAC_WIDTH, operand/result width.
REQ-004 SHALL have parameter ERROR_WIDTH, default 2, error code width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in1, in2  in  DATA_WIDTH  operands {sign, exp, frac}
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands
- out  out  DATA_WIDTH  product
- error  out  ERROR_WIDTH  00 none, 01 overflow, 10 underflow, 11 NaN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sticky_clr  in  1  clears sticky flags
- err_sticky  out  3  {NaN, overflow, underflow} seen since clear

Function
REQ-006 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent sum; S2 significand product; S3 normalise/round/pack; latency 3 cycles without stall.
REQ-007 SHALL accept operands when in_valid & in_ready; deliver result when out_valid & out_ready.
REQ-008 SHALL advance a stage only when the next stage is empty or advancing in the same cycle; in_ready = ~S1_valid | S1_advance.
REQ-009 SHALL sustain one operation per cycle with out_ready held high; results in issue order, none dropped or duplicated.
REQ-010 SHALL hold out and error stable while out_valid & ~out_ready.
REQ-011 SHALL treat exp==0 inputs (zero, subnormal) as signed zero; exp all-ones with frac!=0 as NaN; exp all-ones with frac==0 as infinity.
REQ-012 SHALL compute bias = 2^(EXP_WIDTH-1)-1, biased exponent e = e1+e2-bias (+1 if product MSB set) using EXP_WIDTH+2 signed bits.
REQ-013 SHALL produce canonical NaN (sign 0, exp all-ones, frac MSB 1, rest 0), error 11, for any NaN input or inf x zero.
REQ-014 SHALL produce infinity, sign s1^s2, error 00, for inf x finite-nonzero or inf x inf.
REQ-015 SHALL produce signed zero, error 00, for zero x finite.
REQ-016 SHALL produce signed infinity, error 01, when final e >= all-ones (including carry out of rounding).
REQ-017 SHALL produce signed zero, error 10, when final e <= 0.
REQ-018 SHALL take the FRAC_WIDTH bits below the leading one as result fraction; rounding per REQ-024/025.
REQ-019 SHALL set err_sticky bit on each delivered result with the matching error code; sticky_clr clears all bits; set and clear in same cycle -> set wins.

Reset
REQ-020 SHALL, on rst_n low, immediately clear all stage valids, out_valid=0, err_sticky=0, out=0, error=00, independent of clk.
REQ-021 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-022 SHALL discard in-flight operations when reset asserts mid-operation; none emerge after release.

Configuration
REQ-023 SHALL use macro FP_MUL_RNE_EN to select rounding.
REQ-024 SHALL, with FP_MUL_RNE_EN defined, round to nearest, ties to even, using guard, round and sticky bits; mantissa carry renormalises and increments e.
REQ-025 SHALL, without FP_MUL_RNE_EN, truncate (round toward zero); latency and interface unchanged.

Verification
REQ-026 SHALL cover 0x3F80 x 0x4000 -> 0x4000, error 00, out_valid exactly 3 cycles after acceptance; 0x3FC0 x 0x3FC0 -> 0x4010.
REQ-027 SHALL cover 0x7F80 x 0x0000 -> 0x7FC0, error 11, err_sticky=100; 0x7F00 x 0x4000 -> 0x7F80, error 01.
REQ-028 SHALL cover 0x0080 x 0x3F00 -> 0x0000, error 10, err_sticky[0]=1; then sticky_clr pulse -> err_sticky=000.
REQ-029 SHALL cover 0x3FC1 x 0x3F81 -> 0x3FC3 with FP_MUL_RNE_EN, 0x3FC2 without.
REQ-030 SHALL cover backpressure: out_ready low, issue 4 ops -> 3 accepted, in_ready=0; out_ready high -> all 4 results in order, no gap once streaming.
REQ-031 SHALL cover reset mid-operation: 2 ops in flight, rst_n low 1 cycle -> out_valid=0, no stale results after release.
